// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP core.
// Holds the 16-state TAP encoding, the fixed IR capture pattern and the
// default device identification value.
package jtag_pkg;

    // Conventional IEEE 1149.1 state encoding (4 bits, all 16 codes used).
    typedef enum logic [3:0] {
        ST_EX2DR = 4'h0,
        ST_EX1DR = 4'h1,
        ST_SHDR  = 4'h2,
        ST_PAUDR = 4'h3,
        ST_SELIR = 4'h4,
        ST_UPDDR = 4'h5,
        ST_CAPDR = 4'h6,
        ST_SELDR = 4'h7,
        ST_EX2IR = 4'h8,
        ST_EX1IR = 4'h9,
        ST_SHIR  = 4'hA,
        ST_PAUIR = 4'hB,
        ST_RTI   = 4'hC,
        ST_UPDIR = 4'hD,
        ST_CAPIR = 4'hE,
        ST_TLR   = 4'hF
    } tap_state_t;

    // Pattern loaded into the IR shift stage in Capture-IR (low bits).
    localparam logic [1:0]  IR_CAPTURE     = 2'b01;

    // Default device ID; bit 0 is the mandatory 1149.1 marker bit.
    localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0001;

endpackage

// File: rtl/tap_fsm.sv
// TAP controller: state register, IEEE 1149.1 next-state logic and the
// Moore decodes used by the instruction/data register logic.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output logic [3:0] state_o,
    output logic       tlr_o,
    output logic       select_o,
    output logic       cap_dr_o,
    output logic       sh_dr_o,
    output logic       upd_dr_o,
    output logic       cap_ir_o,
    output logic       sh_ir_o,
    output logic       upd_ir_o
);

    tap_state_t state_q;

    // State register with the 1149.1 transition table folded in.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_q <= ST_TLR;
        end else begin
            case (state_q)
                ST_TLR:   state_q <= tms ? ST_TLR   : ST_RTI;
                ST_RTI:   state_q <= tms ? ST_SELDR : ST_RTI;
                ST_SELDR: state_q <= tms ? ST_SELIR : ST_CAPDR;
                ST_CAPDR: state_q <= tms ? ST_EX1DR : ST_SHDR;
                ST_SHDR:  state_q <= tms ? ST_EX1DR : ST_SHDR;
                ST_EX1DR: state_q <= tms ? ST_UPDDR : ST_PAUDR;
                ST_PAUDR: state_q <= tms ? ST_EX2DR : ST_PAUDR;
                ST_EX2DR: state_q <= tms ? ST_UPDDR : ST_SHDR;
                ST_UPDDR: state_q <= tms ? ST_SELDR : ST_RTI;
                ST_SELIR: state_q <= tms ? ST_TLR   : ST_CAPIR;
                ST_CAPIR: state_q <= tms ? ST_EX1IR : ST_SHIR;
                ST_SHIR:  state_q <= tms ? ST_EX1IR : ST_SHIR;
                ST_EX1IR: state_q <= tms ? ST_UPDIR : ST_PAUIR;
                ST_PAUIR: state_q <= tms ? ST_EX2IR : ST_PAUIR;
                ST_EX2IR: state_q <= tms ? ST_UPDIR : ST_SHIR;
                ST_UPDIR: state_q <= tms ? ST_SELDR : ST_RTI;
                default:  state_q <= ST_TLR;
            endcase
        end
    end

    assign state_o  = state_q;
    assign tlr_o    = (state_q == ST_TLR);
    assign cap_dr_o = (state_q == ST_CAPDR);
    assign sh_dr_o  = (state_q == ST_SHDR);
    assign upd_dr_o = (state_q == ST_UPDDR);
    assign cap_ir_o = (state_q == ST_CAPIR);
    assign sh_ir_o  = (state_q == ST_SHIR);
    assign upd_ir_o = (state_q == ST_UPDIR);
    assign select_o = (state_q == ST_SELIR) || (state_q == ST_CAPIR) ||
                      (state_q == ST_SHIR)  || (state_q == ST_EX1IR) ||
                      (state_q == ST_PAUIR) || (state_q == ST_EX2IR) ||
                      (state_q == ST_UPDIR);

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: TAP FSM, instruction register, bypass register, optional
// IDCODE register and the TDO mux feeding the external user DR chain.
// Optional feature macro: JTAG_IDCODE_EN (IDCODE register present and
// selected after reset; otherwise BYPASS is the reset instruction and the
// IDCODE opcode is treated as a user opcode).
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int                     IR_WIDTH    = 4,
    parameter logic [IR_WIDTH-1:0]    BYPASS_INST = {IR_WIDTH{1'b1}}
`ifdef JTAG_IDCODE_EN
   ,parameter logic [IR_WIDTH-1:0]    IDCODE_INST = IR_WIDTH'(1),
    parameter logic [31:0]            IDCODE_VAL  = IDCODE_DEFAULT
`endif
)(
    input  logic                tck,
    input  logic                reset,
    input  logic                tms,
    input  logic                tdi,
    input  logic                user_tdo,
    output logic                tdo,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [3:0]          tap_state,
    output logic                test_logic_reset,
    output logic                captureDR,
    output logic                shiftDR,
    output logic                updateDR,
    output logic                select
);

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_INST;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET = BYPASS_INST;
`endif
    localparam logic [IR_WIDTH-1:0] IR_CAP_VAL = IR_WIDTH'(IR_CAPTURE);

    logic tlr_s, cap_dr_s, sh_dr_s, upd_dr_s, cap_ir_s, sh_ir_s, upd_ir_s;
    logic sel_bypass_s, sel_idcode_s, sel_user_s;

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
    logic                bypass_q, bypass_d;
`ifdef JTAG_IDCODE_EN
    logic [31:0]         idcode_q, idcode_d;
`endif

    tap_fsm u_fsm (
        .tck      (tck),
        .reset    (reset),
        .tms      (tms),
        .state_o  (tap_state),
        .tlr_o    (tlr_s),
        .select_o (select),
        .cap_dr_o (cap_dr_s),
        .sh_dr_o  (sh_dr_s),
        .upd_dr_o (upd_dr_s),
        .cap_ir_o (cap_ir_s),
        .sh_ir_o  (sh_ir_s),
        .upd_ir_o (upd_ir_s)
    );

    // Instruction decode: anything not owned by the core goes to the user chain.
    assign sel_bypass_s = (ir_out_q == BYPASS_INST);
`ifdef JTAG_IDCODE_EN
    assign sel_idcode_s = (ir_out_q == IDCODE_INST) && !sel_bypass_s;
`else
    assign sel_idcode_s = 1'b0;
`endif
    assign sel_user_s   = !sel_bypass_s && !sel_idcode_s;

    assign captureDR        = cap_dr_s && sel_user_s;
    assign shiftDR          = sh_dr_s  && sel_user_s;
    assign updateDR         = upd_dr_s && sel_user_s;
    assign test_logic_reset = tlr_s;
    assign ir_out           = ir_out_q;

    // Next-state of the IR stages, bypass cell and IDCODE register; pause states hold.
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_out_d   = ir_out_q;
        bypass_d   = bypass_q;
`ifdef JTAG_IDCODE_EN
        idcode_d   = idcode_q;
`endif
        if (tlr_s) begin
            ir_out_d = IR_RESET;
        end else if (cap_ir_s) begin
            ir_shift_d = IR_CAP_VAL;
        end else if (sh_ir_s) begin
            ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
        end else if (upd_ir_s) begin
            ir_out_d = ir_shift_q;
        end else begin
            ir_out_d = ir_out_q;
        end

        if (cap_dr_s && sel_bypass_s) begin
            bypass_d = 1'b0;
        end else if (sh_dr_s && sel_bypass_s) begin
            bypass_d = tdi;
        end else begin
            bypass_d = bypass_q;
        end
`ifdef JTAG_IDCODE_EN
        if (cap_dr_s && sel_idcode_s) begin
            idcode_d = IDCODE_VAL;
        end else if (sh_dr_s && sel_idcode_s) begin
            idcode_d = {tdi, idcode_q[31:1]};
        end else begin
            idcode_d = idcode_q;
        end
`endif
    end

    // Register update; reset abandons any in-flight shift.
    always_ff @(posedge tck) begin
        if (reset) begin
            ir_shift_q <= '0;
            ir_out_q   <= IR_RESET;
            bypass_q   <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idcode_q   <= 32'h0000_0000;
`endif
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_out_q   <= ir_out_d;
            bypass_q   <= bypass_d;
`ifdef JTAG_IDCODE_EN
            idcode_q   <= idcode_d;
`endif
        end
    end

    // TDO mux: IR LSB in Shift-IR, selected DR in Shift-DR, idle otherwise.
    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        if (sh_ir_s) begin
            tdo    = ir_shift_q[0];
            tdo_en = 1'b1;
        end else if (sh_dr_s) begin
            tdo_en = 1'b1;
            if (sel_bypass_s) begin
                tdo = bypass_q;
`ifdef JTAG_IDCODE_EN
            end else if (sel_idcode_s) begin
                tdo = idcode_q[0];
`endif
            end else begin
                tdo = user_tdo;
            end
        end else begin
            tdo    = 1'b0;
            tdo_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_core.sv
// Directed self-checking bench for jtag_tap_core (default parameters).
// Works with and without JTAG_IDCODE_EN defined.
module tb_jtag_tap_core;
    import jtag_pkg::*;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] EXP_IR_RST = 4'h1;
`else
    localparam logic [3:0] EXP_IR_RST = 4'hF;
`endif

    logic       tck = 1'b0;
    logic       reset = 1'b1;
    logic       tms = 1'b0;
    logic       tdi = 1'b0;
    logic       user_tdo = 1'b0;
    logic       tdo, tdo_en, test_logic_reset, captureDR, shiftDR, updateDR, select;
    logic [3:0] ir_out, tap_state;
    int         checks = 0;
    int         failures = 0;

    jtag_tap_core dut (
        .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .user_tdo(user_tdo),
        .tdo(tdo), .tdo_en(tdo_en), .ir_out(ir_out), .tap_state(tap_state),
        .test_logic_reset(test_logic_reset), .captureDR(captureDR),
        .shiftDR(shiftDR), .updateDR(updateDR), .select(select)
    );

    always #5 tck = ~tck;

    // One TAP clock: drive tms/tdi, take the edge, settle 1 time unit.
    task automatic tick(input logic t_ms, input logic t_di);
        tms = t_ms;
        tdi = t_di;
        @(posedge tck);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        checks++; if (tap_state !== ST_TLR) begin failures++; $display("FAIL rst_state got %h exp %h", tap_state, ST_TLR); end
        checks++; if (test_logic_reset !== 1'b1) begin failures++; $display("FAIL rst_tlr got %b exp 1", test_logic_reset); end
        checks++; if (ir_out !== EXP_IR_RST) begin failures++; $display("FAIL rst_ir got %h exp %h", ir_out, EXP_IR_RST); end
        checks++; if ({tdo_en, captureDR, shiftDR, updateDR, select} !== 5'b0) begin
            failures++; $display("FAIL rst_outs got %b exp 00000", {tdo_en, captureDR, shiftDR, updateDR, select}); end
        tick(1'b0, 1'b0);
        checks++; if (tap_state !== ST_RTI) begin failures++; $display("FAIL to_rti got %h exp %h", tap_state, ST_RTI); end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        checks++; if (tap_state !== ST_TLR || ir_out !== EXP_IR_RST || tdo_en !== 1'b0) begin
            failures++; $display("FAIL tms5_tlr got st=%h ir=%h en=%b exp st=f ir=%h en=0", tap_state, ir_out, tdo_en, EXP_IR_RST); end
        tick(1'b0, 1'b0);
    endtask

`ifdef JTAG_IDCODE_EN
    task automatic test_idcode();
        logic [31:0] obs;
        logic        en_ok, strobe_seen;
        en_ok = 1'b1; strobe_seen = 1'b0; obs = 32'h0;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            obs[i] = tdo;
            if (tdo_en !== 1'b1) en_ok = 1'b0;
            if (shiftDR !== 1'b0) strobe_seen = 1'b1;
            tick(i == 31, 1'b0);
        end
        checks++; if (obs !== 32'h1000_0001) begin failures++; $display("FAIL idcode got %h exp 10000001", obs); end
        checks++; if (en_ok !== 1'b1) begin failures++; $display("FAIL idcode_en got %b exp 1", en_ok); end
        checks++; if (strobe_seen !== 1'b0) begin failures++; $display("FAIL idcode_strobe got %b exp 0", strobe_seen); end
        checks++; if (tap_state !== ST_EX1DR) begin failures++; $display("FAIL idcode_exit got %h exp %h", tap_state, ST_EX1DR); end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask
`endif

    // From RTI: load an instruction via Capture/Shift/Update-IR, back to RTI.
    task automatic test_ir_load(input logic [3:0] val);
        logic [3:0] obs;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        checks++; if (tap_state !== ST_SHIR || select !== 1'b1 || tdo_en !== 1'b1) begin
            failures++; $display("FAIL ir_shst got st=%h sel=%b en=%b exp st=a sel=1 en=1", tap_state, select, tdo_en); end
        for (int i = 0; i < 4; i++) begin
            obs[i] = tdo;
            tick(i == 3, val[i]);
        end
        checks++; if (obs !== 4'b0001) begin failures++; $display("FAIL ir_capture got %b exp 0001", obs); end
        tick(1'b1, 1'b0);
        checks++; if (tap_state !== ST_UPDIR) begin failures++; $display("FAIL ir_upd_state got %h exp %h", tap_state, ST_UPDIR); end
        tick(1'b0, 1'b0);
        checks++; if (ir_out !== val || select !== 1'b0) begin
            failures++; $display("FAIL ir_load got ir=%h sel=%b exp ir=%h sel=0", ir_out, select, val); end
    endtask

    // From RTI with BYPASS selected: tdi 1,0,1,1 must come out as 0,1,0,1.
    task automatic test_bypass();
        logic [3:0] pat, obs;
        logic       strobe_seen;
        pat = 4'b1101; strobe_seen = 1'b0;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            obs[i] = tdo;
            if (shiftDR !== 1'b0) strobe_seen = 1'b1;
            tick(i == 3, pat[i]);
        end
        checks++; if (obs !== 4'b1010) begin failures++; $display("FAIL bypass got %b exp 1010", obs); end
        checks++; if (strobe_seen !== 1'b0) begin failures++; $display("FAIL bypass_strobe got %b exp 0", strobe_seen); end
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic test_user();
        logic [3:0] obs;
        logic       en_ok;
        en_ok = 1'b1;
        test_ir_load(4'h5);
        tick(1'b1, 1'b0);
        checks++; if (captureDR !== 1'b0) begin failures++; $display("FAIL usr_seldr got %b exp 0", captureDR); end
        tick(1'b0, 1'b0);
        checks++; if ({captureDR, shiftDR, updateDR} !== 3'b100) begin
            failures++; $display("FAIL usr_cap got %b exp 100", {captureDR, shiftDR, updateDR}); end
        tick(1'b0, 1'b0);
        checks++; if ({captureDR, shiftDR, updateDR} !== 3'b010) begin
            failures++; $display("FAIL usr_shift got %b exp 010", {captureDR, shiftDR, updateDR}); end
        for (int i = 0; i < 4; i++) begin
            user_tdo = (i % 2 == 1);
            #1;
            obs[i] = tdo;
            if (tdo_en !== 1'b1) en_ok = 1'b0;
            tick(i == 3, 1'b0);
        end
        checks++; if (obs !== 4'b1010 || en_ok !== 1'b1) begin
            failures++; $display("FAIL usr_tdo got %b en=%b exp 1010 en=1", obs, en_ok); end
        checks++; if ({captureDR, shiftDR, updateDR} !== 3'b000) begin
            failures++; $display("FAIL usr_ex1 got %b exp 000", {captureDR, shiftDR, updateDR}); end
        tick(1'b1, 1'b0);
        checks++; if ({captureDR, shiftDR, updateDR} !== 3'b001) begin
            failures++; $display("FAIL usr_upd got %b exp 001", {captureDR, shiftDR, updateDR}); end
        tick(1'b0, 1'b0);
        checks++; if (updateDR !== 1'b0) begin failures++; $display("FAIL usr_rti got %b exp 0", updateDR); end
        user_tdo = 1'b0;
    endtask

    // Pause-IR holds the shift stage; reset mid-Shift-IR drops the shift.
    task automatic test_pause_and_reset();
        logic [2:0] obs;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);              // shift 1 -> 1000
        tick(1'b1, 1'b0);              // shift 0 -> 0100, to Ex1IR
        tick(1'b0, 1'b1);              // Pause-IR
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        checks++; if (tap_state !== ST_PAUIR || tdo_en !== 1'b0) begin
            failures++; $display("FAIL pause_state got st=%h en=%b exp st=b en=0", tap_state, tdo_en); end
        tick(1'b1, 1'b1); tick(1'b0, 1'b1);
        checks++; if (tap_state !== ST_SHIR) begin failures++; $display("FAIL resume got %h exp %h", tap_state, ST_SHIR); end
        obs[0] = tdo; tick(1'b0, 1'b1);
        obs[1] = tdo; tick(1'b0, 1'b0);
        obs[2] = tdo;
        checks++; if (obs !== 3'b100) begin failures++; $display("FAIL pause_hold got %b exp 100", obs); end
        reset = 1'b1;
        tick(1'b0, 1'b1);
        reset = 1'b0;
        checks++; if (tap_state !== ST_TLR || ir_out !== EXP_IR_RST || tdo_en !== 1'b0) begin
            failures++; $display("FAIL mid_reset got st=%h ir=%h en=%b exp st=f ir=%h en=0", tap_state, ir_out, tdo_en, EXP_IR_RST); end
        tick(1'b0, 1'b0);
        checks++; if (ir_out !== EXP_IR_RST) begin failures++; $display("FAIL mid_reset_ir got %h exp %h", ir_out, EXP_IR_RST); end
    endtask

    // Five tms=1 from Pause-DR reach TLR, which restores the reset instruction.
    task automatic test_tlr_force();
        test_ir_load(4'h5);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        checks++; if (tap_state !== ST_PAUDR) begin failures++; $display("FAIL to_paudr got %h exp %h", tap_state, ST_PAUDR); end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        checks++; if (tap_state !== ST_SELIR || ir_out !== 4'h5) begin
            failures++; $display("FAIL four_ones got st=%h ir=%h exp st=4 ir=5", tap_state, ir_out); end
        tick(1'b1, 1'b0);
        checks++; if (tap_state !== ST_TLR || test_logic_reset !== 1'b1) begin
            failures++; $display("FAIL five_ones got st=%h tlr=%b exp st=f tlr=1", tap_state, test_logic_reset); end
        tick(1'b1, 1'b0);
        checks++; if (ir_out !== EXP_IR_RST) begin failures++; $display("FAIL tlr_ir got %h exp %h", ir_out, EXP_IR_RST); end
    endtask

    initial begin
        test_reset();
`ifdef JTAG_IDCODE_EN
        test_idcode();
`else
        test_bypass();
`endif
        test_ir_load(4'hF);
        test_bypass();
        test_user();
        test_pause_and_reset();
        test_tlr_force();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
